// File: rtl/fifo_ch_scheduler.sv
// Round-robin time-division scheduler for a bank of single-channel FIFOs.
// A granted channel is flushed, streamed for a burst of len cycles, then left
// idle long enough for the FIFO's negedge read-enable pipeline to empty.
//
// Handshake: req is a level held by each requester until it sees its grant;
// there is no ready/ack back to the requester other than gnt_id/busy.
// The transaction is acknowledged by a single-cycle done pulse, and aborted
// (sticky until the next grant) tells whether it ended early.
`timescale 1ns/1ps
module fifo_ch_scheduler #(
    parameter int NCH       = 4,
    parameter int IW        = 2,
    parameter int CW        = 13,
    parameter int FLUSH_CYC = 2,
    parameter int DRAIN_CYC = 4
) (
    input  logic           CLK,
    input  logic           RST_X,
    input  logic           en,
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  len,
    input  logic           abort,
    output logic [NCH-1:0] sel,
    output logic [NCH-1:0] frst,
    output logic [IW-1:0]  gnt_id,
    output logic           busy,
    output logic           done,
    output logic           aborted,
    output logic [1:0]     state_dbg
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    localparam logic [7:0] FLUSH_N = 8'(FLUSH_CYC);
    localparam logic [7:0] DRAIN_N = 8'(DRAIN_CYC);

    logic [1:0]     state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;     // remaining stream cycles
    logic [7:0]     ph_q, ph_d;       // remaining flush/drain cycles
    logic           ab_q, ab_d;
    logic [NCH-1:0] sel_q, sel_d;
    logic [NCH-1:0] frst_q, frst_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [IW-1:0]  win;
    logic [NCH-1:0] gnt_oh;

    // First requesting channel at or above ptr, wrapping around.
    function automatic logic [IW-1:0] rr_pick(input logic [NCH-1:0] r,
                                              input logic [IW-1:0]  p);
        logic [IW-1:0] w;
        logic [IW-1:0] ix;
        logic          f;
        w  = '0;
        ix = '0;
        f  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            ix = IW'((int'(p) + i) % NCH);
            if (!f && r[ix]) begin
                f = 1'b1;
                w = ix;
            end
        end
        return w;
    endfunction

    // Arbitration, phase sequencing and next-cycle output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        ab_d    = ab_q;
        done_d  = 1'b0;
        win     = rr_pick(req, ptr_q);
        case (state_q)
            S_IDLE: begin
                if (en && (|req)) begin
                    gnt_d   = win;
                    ptr_d   = IW'((int'(win) + 1) % NCH);
                    cnt_d   = len;
                    ph_d    = FLUSH_N;
                    ab_d    = 1'b0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (abort) begin
                    ab_d    = 1'b1;
                    ph_d    = DRAIN_N;
                    state_d = S_DRAIN;
                end else if (ph_q == 8'd1) begin
                    if (cnt_q != '0) begin
                        state_d = S_STREAM;
                    end else begin
                        ph_d    = DRAIN_N;
                        state_d = S_DRAIN;
                    end
                end else begin
                    ph_d = ph_q - 8'd1;
                end
            end
            S_STREAM: begin
                if (abort || cnt_q == CW'(1)) begin
                    ab_d    = ab_q | abort;
                    ph_d    = DRAIN_N;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                if (ph_q == 8'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ph_d = ph_q - 8'd1;
                end
            end
        endcase
        gnt_oh = {{(NCH-1){1'b0}}, 1'b1} << gnt_d;
        sel_d  = (state_d == S_STREAM) ? gnt_oh : '0;
        frst_d = (state_d == S_FLUSH)  ? gnt_oh : '0;
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            ab_q    <= 1'b0;
            sel_q   <= '0;
            frst_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            ab_q    <= ab_d;
            sel_q   <= sel_d;
            frst_q  <= frst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel       = sel_q;
    assign frst      = frst_q;
    assign gnt_id    = gnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = ab_q;
    assign state_dbg = state_q;

endmodule
